// File: rtl/hashmap_core.sv
// hashmap_core: multi-table (cuckoo) hash map with a pipelined lookup path,
// lookup-relative modify/delete with forwarding, and a background insert
// engine that displaces colliding entries round-robin across the tables.
module hashmap_core #(
  parameter int NUM_TABLES    = 2,
  parameter int NUM_ADDR_BITS = 4,
  parameter int NUM_KEY_BITS  = 8,
  parameter int NUM_VAL_BITS  = 8,
  parameter int NUM_PIPES     = 2,
  parameter int EN_INS_SEL    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_KEY_BITS-1:0] f_key,
  input  logic                    insert,
  input  logic [NUM_KEY_BITS-1:0] ins_key,
  input  logic [NUM_VAL_BITS-1:0] ins_value,
  output logic                    busy,
  input  logic                    lookup,
  input  logic [NUM_KEY_BITS-1:0] key,
  input  logic                    modify,
  input  logic                    del,
  input  logic [NUM_VAL_BITS-1:0] mod_value,
  output logic                    valid,
  output logic [NUM_VAL_BITS-1:0] value
);

  localparam int T  = NUM_TABLES;
  localparam int A  = NUM_ADDR_BITS;
  localparam int K  = NUM_KEY_BITS;
  localparam int V  = NUM_VAL_BITS;
  localparam int P  = NUM_PIPES;
  localparam int N  = 1 << A;
  localparam int TW = (T > 1) ? $clog2(T) : 1;
  localparam int NC = (K + A - 1) / A;
  localparam int PW = NC * A;

  // Table i: XOR-fold of (key ^ C_i) into A-bit chunks. Chunk j is rotated by
  // i*j first; a plain fold is linear, so without the rotation keys colliding
  // in one table would collide in every table and cuckoo could never resolve.
  function automatic logic [A-1:0] f_hash(input logic [K-1:0] k, input int t);
    logic [PW-1:0] x;
    logic [A-1:0]  ch;
    logic [A-1:0]  acc;
    int            r;
    x   = PW'(k ^ K'(t * 32'h5B));
    acc = '0;
    for (int j = 0; j < NC; j++) begin
      ch = x[j*A +: A];
      r  = (t * j) % A;
      if (r != 0) ch = (ch << r) | (ch >> (A - r));
      acc = acc ^ ch;
    end
    return acc;
  endfunction

  // Table storage: valid bits are control (reset), key/value are data
  logic         r_tv   [T][N];
  logic [K-1:0] r_tk   [T][N];
  logic [V-1:0] r_tval [T][N];

  // Displacement register of the insert engine
  logic          r_dv;
  logic [TW-1:0] r_dtab;
  logic [K-1:0]  r_dkey;
  logic [V-1:0]  r_dval;

  // Lookup pipeline, stage s holds the lookup issued s+1 cycles ago
  logic         r_req_p [P];
  logic         r_hit_p [P];
  logic [V-1:0] r_val_p [P];
  logic [K-1:0] r_key_p [P];

  logic [A-1:0]  w_l_addr [T];
  logic [A-1:0]  w_m_addr [T];
  logic [A-1:0]  w_e_addr [T];
  logic [A-1:0]  w_f_addr [T];
  logic          w_m_hit_t [T];
  logic          w_m_hit_d;
  logic          w_mod_en;
  logic [K-1:0]  w_mkey;
  logic          w_lk_hit;
  logic [V-1:0]  w_lk_val;
  logic [TW-1:0] w_e_tab;
  logic [TW-1:0] w_e_next;
  logic          w_e_found;
  logic          w_e_place;
  logic          w_stall;
  logic          w_e_go;
  logic          w_accept;
  logic [3:0]    w_f_cnt;

  // Per-table candidate addresses for lookup, modify, insert engine and tracked key
  always_comb begin
    for (int i = 0; i < T; i++) begin
      w_l_addr[i] = f_hash(key, i);
      w_m_addr[i] = f_hash(r_key_p[P-1], i);
      w_e_addr[i] = f_hash(r_dkey, i);
      w_f_addr[i] = f_hash(f_key, i);
    end
  end

  // Searches, insert target selection and modify/insert arbitration
  always_comb begin
    w_mkey    = r_key_p[P-1];
    w_mod_en  = modify && r_req_p[P-1] && r_hit_p[P-1];
    w_m_hit_d = r_dv && (r_dkey == w_mkey);
    w_lk_hit  = r_dv && (r_dkey == key);
    w_lk_val  = w_lk_hit ? r_dval : '0;
    w_e_tab   = r_dtab;
    w_e_found = 1'b0;
    w_f_cnt   = {3'b000, r_dv && (r_dkey == f_key)};
    for (int i = 0; i < T; i++) begin
      w_m_hit_t[i] = r_tv[i][w_m_addr[i]] && (r_tk[i][w_m_addr[i]] == w_mkey);
      if (r_tv[i][w_l_addr[i]] && (r_tk[i][w_l_addr[i]] == key)) begin
        w_lk_hit = 1'b1;
        w_lk_val = r_tval[i][w_l_addr[i]];
      end
      if (r_tv[i][w_f_addr[i]] && (r_tk[i][w_f_addr[i]] == f_key))
        w_f_cnt = w_f_cnt + 4'd1;
      if ((EN_INS_SEL != 0) && !w_e_found && !r_tv[i][w_e_addr[i]]) begin
        w_e_found = 1'b1;
        w_e_tab   = TW'(i);
      end
    end
    w_e_place = !r_tv[w_e_tab][w_e_addr[w_e_tab]];
    // A modify owns the slot (or displacement register) it targets this cycle
    w_stall   = w_mod_en && (w_m_hit_d ||
                (w_m_hit_t[w_e_tab] && (w_m_addr[w_e_tab] == w_e_addr[w_e_tab])));
    w_e_go    = r_dv && !w_stall;
    w_e_next  = (w_e_tab == TW'(T - 1)) ? '0 : w_e_tab + TW'(1);
    w_accept  = insert && !r_dv;
  end

  // Control state: slot valid bits, engine occupancy, lookup pipeline results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T; i++)
        for (int j = 0; j < N; j++)
          r_tv[i][j] <= 1'b0;
      r_dv   <= 1'b0;
      r_dtab <= '0;
      for (int s = 0; s < P; s++) begin
        r_req_p[s] <= 1'b0;
        r_hit_p[s] <= 1'b0;
        r_val_p[s] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_dv   <= 1'b1;
        r_dtab <= '0;
      end else if (w_e_go) begin
        r_tv[w_e_tab][w_e_addr[w_e_tab]] <= 1'b1;
        r_dv   <= !w_e_place;
        r_dtab <= w_e_next;
      end else if (w_mod_en && w_m_hit_d && del) begin
        r_dv <= 1'b0;
      end
      for (int i = 0; i < T; i++)
        if (w_mod_en && del && w_m_hit_t[i])
          r_tv[i][w_m_addr[i]] <= 1'b0;
      r_req_p[0] <= lookup;
      if (lookup && w_mod_en && (key == w_mkey)) begin
        r_hit_p[0] <= !del;
        r_val_p[0] <= mod_value;
      end else begin
        r_hit_p[0] <= lookup && w_lk_hit;
        r_val_p[0] <= w_lk_val;
      end
      for (int s = 1; s < P; s++) begin
        r_req_p[s] <= r_req_p[s-1];
        if (r_req_p[s-1] && w_mod_en && (r_key_p[s-1] == w_mkey)) begin
          r_hit_p[s] <= !del;
          r_val_p[s] <= mod_value;
        end else begin
          r_hit_p[s] <= r_hit_p[s-1];
          r_val_p[s] <= r_val_p[s-1];
        end
      end
    end
  end

  // Data state: table keys/values, displacement register contents, lookup keys
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dkey <= ins_key;
      r_dval <= ins_value;
    end else if (w_e_go) begin
      r_tk[w_e_tab][w_e_addr[w_e_tab]]   <= r_dkey;
      r_tval[w_e_tab][w_e_addr[w_e_tab]] <= r_dval;
      r_dkey <= r_tk[w_e_tab][w_e_addr[w_e_tab]];
      r_dval <= r_tval[w_e_tab][w_e_addr[w_e_tab]];
    end else if (w_mod_en && w_m_hit_d && !del) begin
      r_dval <= mod_value;
    end
    for (int i = 0; i < T; i++)
      if (w_mod_en && !del && w_m_hit_t[i])
        r_tval[i][w_m_addr[i]] <= mod_value;
    r_key_p[0] <= key;
    for (int s = 1; s < P; s++)
      r_key_p[s] <= r_key_p[s-1];
  end

  // The tracked key never lives in more than one place at once
  a_unique_key: assert property (@(posedge clk) disable iff (!rst_n) w_f_cnt <= 4'd1);

  assign busy  = r_dv;
  assign valid = r_hit_p[P-1];
  assign value = r_val_p[P-1];

endmodule

// File: tb/tb_hashmap_core.sv
// Directed bench for hashmap_core: cycle table for basic lookup/insert/modify,
// then hand-written sequences for read-modify-write, collisions and reset.
module tb_hashmap_core;

  logic       clk;
  logic       rst_n;
  logic [7:0] f_key;
  logic       insert;
  logic [7:0] ins_key;
  logic [7:0] ins_value;
  logic       busy;
  logic       lookup;
  logic [7:0] key;
  logic       modify;
  logic       del;
  logic [7:0] mod_value;
  logic       valid;
  logic [7:0] value;

  int n_checks = 0;
  int n_errors = 0;

  hashmap_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_key     (f_key),
    .insert    (insert),
    .ins_key   (ins_key),
    .ins_value (ins_value),
    .busy      (busy),
    .lookup    (lookup),
    .key       (key),
    .modify    (modify),
    .del       (del),
    .mod_value (mod_value),
    .valid     (valid),
    .value     (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ins;
    logic [7:0] ik;
    logic [7:0] iv;
    logic       lk;
    logic [7:0] lkey;
    logic       md;
    logic       dl;
    logic [7:0] mv;
    logic       chk;
    logic       ev;
    logic [7:0] eval;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic ins, input logic [7:0] ik, input logic [7:0] iv,
                     input logic lk, input logic [7:0] lkey, input logic md, input logic dl,
                     input logic [7:0] mv, input logic chk, input logic ev, input logic [7:0] eval,
                     input logic eb);
    vec_t v;
    v.name = nm; v.ins = ins; v.ik = ik; v.iv = iv; v.lk = lk; v.lkey = lkey;
    v.md = md; v.dl = dl; v.mv = mv; v.chk = chk; v.ev = ev; v.eval = eval; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    insert = 1'b0; ins_key = '0; ins_value = '0;
    lookup = 1'b0; key = '0; modify = 1'b0; del = 1'b0; mod_value = '0;
  endtask

  // Insert one entry, then count how many cycles busy stays high
  task automatic do_insert(input string nm, input logic [7:0] k, input logic [7:0] v,
                           input int exp_cycles);
    int n;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_idle_before"}, busy, 0);
    insert = 1'b1; ins_key = k; ins_value = v;
    @(negedge clk);
    insert = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk({nm, "_busy_cycles"}, n, exp_cycles);
  endtask

  // Single lookup, result checked two cycles later
  task automatic lk_check(input string nm, input logic [7:0] k, input logic ev,
                          input logic [7:0] eval);
    @(negedge clk);
    lookup = 1'b1; key = k;
    @(negedge clk);
    lookup = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, valid, ev);
    if (ev) chk({nm, "_value"}, value, eval);
  endtask

  logic [7:0] t4_keys [6];
  logic [7:0] t4_vals [6];

  initial begin
    idle_inputs();
    f_key = 8'h12;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_value", value, 0);

    //  name           ins ik     iv     lk lkey   md dl mv     chk ev eval   eb
    add("t1_lookup",    0, 8'h00, 8'h00, 1, 8'h12, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t1_idle",      0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t2_ins_lk",    1, 8'h12, 8'hA5, 1, 8'h12, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t2_lk_next",   0, 8'h00, 8'h00, 1, 8'h12, 0, 0, 8'h00, 1,  0, 8'h00, 1);
    add("t2_idle",      0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t3_lk1",       0, 8'h00, 8'h00, 1, 8'h12, 0, 0, 8'h00, 1,  1, 8'hA5, 0);
    add("t3_lk2",       0, 8'h00, 8'h00, 1, 8'h12, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t3_mod",       0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h3C, 1,  1, 8'hA5, 0);
    add("t3_del",       0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h00, 1,  1, 8'h3C, 0);
    add("t3_lk3",       0, 8'h00, 8'h00, 1, 8'h12, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t3_lk4",       0, 8'h00, 8'h00, 1, 8'h12, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t3_mod_miss",  0, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h77, 1,  0, 8'h00, 0);
    add("t5_ins",       1, 8'h12, 8'h05, 0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 0);
    add("t5_busy",      0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 1);
    add("t5_idle",      0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1,  0, 8'h00, 0);

    foreach (vecs[i]) begin
      chk({vecs[i].name, "_busy"}, busy, vecs[i].eb);
      if (vecs[i].chk) begin
        chk({vecs[i].name, "_valid"}, valid, vecs[i].ev);
        if (vecs[i].ev) chk({vecs[i].name, "_value"}, value, vecs[i].eval);
      end
      insert = vecs[i].ins; ins_key = vecs[i].ik; ins_value = vecs[i].iv;
      lookup = vecs[i].lk; key = vecs[i].lkey;
      modify = vecs[i].md; del = vecs[i].dl; mod_value = vecs[i].mv;
      @(negedge clk);
    end
    idle_inputs();

    // Back-to-back read-modify-write increment of key 0x12 starting at 0x05
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("t5_rmw_valid", valid, 1);
        chk("t5_rmw_value", value, 32'(8'h05 + 8'(i - 2)));
      end
      modify    = (i >= 2);
      mod_value = 8'h05 + 8'(i - 2) + 8'h01;
      lookup    = (i < 10);
      key       = 8'h12;
    end
    @(negedge clk);
    idle_inputs();
    lk_check("t5_final", 8'h12, 1'b1, 8'h0F);

    // Keys 0x21, 0x30, 0x03 share table-0 slot 3; 0x22 parks in table 1 so
    // inserting 0x30 has to evict
    do_insert("t4_ins00", 8'h00, 8'h01, 1);
    do_insert("t4_ins22", 8'h22, 8'h02, 1);
    do_insert("t4_ins21", 8'h21, 8'h0A, 1);
    do_insert("t4_ins30", 8'h30, 8'h0B, 2);
    do_insert("t4_ins03", 8'h03, 8'h0C, 1);
    t4_keys = '{8'h00, 8'h22, 8'h21, 8'h30, 8'h03, 8'h12};
    t4_vals = '{8'h01, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0F};
    for (int i = 0; i < 6; i++)
      lk_check($sformatf("t4_hit_%02h", t4_keys[i]), t4_keys[i], 1'b1, t4_vals[i]);

    // Reset in the middle of an eviction chain
    @(negedge clk);
    insert = 1'b1; ins_key = 8'hFC; ins_value = 8'h0D;
    @(negedge clk);
    insert = 1'b0;
    chk("t6_busy_accept", busy, 1);
    @(negedge clk);
    chk("t6_busy_evicting", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy_in_reset", busy, 0);
    chk("t6_valid_in_reset", valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy_after", busy, 0);
    for (int i = 0; i < 6; i++)
      lk_check($sformatf("t6_miss_%02h", t4_keys[i]), t4_keys[i], 1'b0, 8'h00);
    lk_check("t6_miss_fc", 8'hFC, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
